// File: rtl/stage_to_bf_pkg.sv
// Shared constants and helpers for the stage read-out path and its butterfly
// address generator.
package stage_to_bf_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int STB_N         = 8;
  localparam int STB_MSG_WIDTH = 1;
  localparam int STB_LOG_N     = clog2(STB_N);

endpackage

// File: rtl/stage_to_bf_addr_gen.sv
// Radix-2 butterfly address map: pair index p at level s -> (addr0, addr1, tw).
// Pure combinational; also used by the stage-fill side for in-place write-back.
module bf_addr_gen
  import stage_to_bf_pkg::*;
#(
  parameter int LOG_N = STB_LOG_N
) (
  input  logic [LOG_N-2:0] p,
  input  logic [LOG_N-1:0] s,
  output logic [LOG_N-1:0] addr0,
  output logic [LOG_N-1:0] addr1,
  output logic [LOG_N-2:0] tw
);

  logic [LOG_N-1:0] p_ext;
  logic [LOG_N-1:0] span;
  logic [LOG_N-1:0] grp;
  logic [LOG_N-1:0] ofs;

  always_comb begin
    p_ext = {1'b0, p};
    span  = LOG_N'(1) << s;
    grp   = p_ext >> s;
    ofs   = p_ext & (span - LOG_N'(1));
    addr0 = (grp << (s + LOG_N'(1))) + ofs;
    addr1 = addr0 + span;
    // ofs < span, so the shifted value never reaches the dropped top bit
    tw    = (LOG_N-1)'(ofs << (LOG_N'(LOG_N - 1) - s));
  end

endmodule

// File: rtl/stage_to_bf.sv
// Drains one filled FFT stage in butterfly-pair order for a single level and
// streams pairs, twiddle index and metadata to the butterfly unit.
//
//   state    | meaning
//   S_IDLE   | waiting for start; level checked here
//   S_ISSUE  | one pair address + mstore pop per cycle, N/2 cycles
//   S_DRAIN  | two cycles letting the read/output pipeline empty
module stage_to_bf
  import stage_to_bf_pkg::*;
#(
  parameter int N      = STB_N,
  parameter int LOG_N  = STB_LOG_N,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = STB_MSG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LOG_N-1:0]  level,
  output logic [LOG_N-1:0]  addr0,
  output logic [LOG_N-1:0]  addr1,
  input  logic [WIDTH-1:0]  in_data0,
  input  logic [WIDTH-1:0]  in_data1,
  output logic              out_mread,
  input  logic [MWIDTH-1:0] in_m,
  output logic              out_nd,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [LOG_N-2:0]  out_tw,
  output logic [MWIDTH-1:0] out_m,
  output logic              finished,
  output logic              error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LOG_N-2:0] P_LAST    = (LOG_N-1)'(N/2 - 1);
  localparam logic [LOG_N-1:0] LVL_LIMIT = LOG_N'(LOG_N);

  logic [1:0]       state;
  logic [LOG_N-2:0] p;
  logic [LOG_N-1:0] lvl;
  logic             drain_cnt;

  logic [LOG_N-2:0] sel_p;
  logic [LOG_N-1:0] sel_s;
  logic [LOG_N-1:0] gen_a0;
  logic [LOG_N-1:0] gen_a1;
  logic [LOG_N-2:0] gen_tw;

  logic [LOG_N-2:0] tw1;
  logic [LOG_N-2:0] tw2;
  logic             last1;
  logic             last2;
  logic             vld2;

  // Addresses are registered, so the generator looks one pair ahead; on the
  // start cycle it sees pair 0 at the incoming level.
  always_comb begin
    sel_p = (state == S_IDLE) ? '0 : p + (LOG_N-1)'(1);
    sel_s = (state == S_IDLE) ? level : lvl;
  end

  bf_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
    .p     (sel_p),
    .s     (sel_s),
    .addr0 (gen_a0),
    .addr1 (gen_a1),
    .tw    (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      p         <= '0;
      lvl       <= '0;
      drain_cnt <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      tw1       <= '0;
      last1     <= 1'b0;
      out_mread <= 1'b0;
      error     <= 1'b0;
    end else begin
      out_mread <= 1'b0;
      last1     <= 1'b0;
      if (start && state != S_IDLE) error <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (level < LVL_LIMIT) begin
              lvl       <= level;
              p         <= '0;
              state     <= S_ISSUE;
              addr0     <= gen_a0;
              addr1     <= gen_a1;
              tw1       <= gen_tw;
              last1     <= (sel_p == P_LAST);
              out_mread <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (p == P_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b1;
          end else begin
            p         <= sel_p;
            addr0     <= gen_a0;
            addr1     <= gen_a1;
            tw1       <= gen_tw;
            last1     <= (sel_p == P_LAST);
            out_mread <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 1'b0) state <= S_IDLE;
          else drain_cnt <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory and mstore both answer one cycle after the request; outputs add one more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2      <= 1'b0;
      tw2       <= '0;
      last2     <= 1'b0;
      out_nd    <= 1'b0;
      finished  <= 1'b0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_tw    <= '0;
      out_m     <= '0;
    end else begin
      vld2     <= out_mread;
      tw2      <= tw1;
      last2    <= last1 && out_mread;
      out_nd   <= vld2;
      finished <= last2;
      if (vld2) begin
        out_data0 <= in_data0;
        out_data1 <= in_data1;
        out_tw    <= tw2;
        out_m     <= in_m;
      end
    end
  end

endmodule

// File: tb/tb_stage_to_bf.sv
// Bench for stage_to_bf: memory/mstore models, a per-cycle schedule model of
// the expected outputs, and literal pins for the documented pair sequences.
module tb_stage_to_bf;

  localparam int N      = 8;
  localparam int LOG_N  = 3;
  localparam int WIDTH  = 32;
  localparam int MWIDTH = 1;
  localparam int DEPTH  = 1024;
  localparam int BIG    = 1 << 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LOG_N-1:0]  level = '0;
  logic [LOG_N-1:0]  addr0, addr1;
  logic [WIDTH-1:0]  in_data0 = '0, in_data1 = '0;
  logic              out_mread;
  logic [MWIDTH-1:0] in_m = '0;
  logic              out_nd;
  logic [WIDTH-1:0]  out_data0, out_data1;
  logic [LOG_N-2:0]  out_tw;
  logic [MWIDTH-1:0] out_m;
  logic              finished;
  logic              error;

  stage_to_bf #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .MWIDTH(MWIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .level(level),
    .addr0(addr0), .addr1(addr1), .in_data0(in_data0), .in_data1(in_data1),
    .out_mread(out_mread), .in_m(in_m), .out_nd(out_nd),
    .out_data0(out_data0), .out_data1(out_data1), .out_tw(out_tw),
    .out_m(out_m), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stage memory and mstore: both answer one cycle after the request
  logic [WIDTH-1:0]  mem [N];
  logic [MWIDTH-1:0] m_const;
  always @(posedge clk) begin
    in_data0 <= mem[addr0];
    in_data1 <= mem[addr1];
    if (out_mread) in_m <= m_const;
  end

  // expected schedule, indexed by cycle
  bit               e_nd [DEPTH];
  bit               e_mr [DEPTH];
  bit               e_fin[DEPTH];
  logic [LOG_N-1:0] e_a0 [DEPTH];
  logic [LOG_N-1:0] e_a1 [DEPTH];
  logic [WIDTH-1:0] e_d0 [DEPTH];
  logic [WIDTH-1:0] e_d1 [DEPTH];
  logic [LOG_N-2:0] e_tw [DEPTH];
  logic [MWIDTH-1:0] e_m [DEPTH];
  int err_from = BIG;
  int busy_until = 0;

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] q_d0[$];
  logic [WIDTH-1:0] q_d1[$];
  logic [LOG_N-2:0] q_tw[$];
  int fin_cyc = -1;
  int err_rise = -1;
  int mr_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model_from(input int c);
    for (int i = c; i < DEPTH; i++) begin
      e_nd[i] = 0; e_mr[i] = 0; e_fin[i] = 0;
    end
  endtask

  // Pair p at level s: groups of 2*span, partner span apart, twiddle stride N/(2*span).
  task automatic model_run(input int c0, input int s);
    int span, g, o, a0, a1, tw;
    span = 1 << s;
    for (int p = 0; p < N/2; p++) begin
      g  = p / span;
      o  = p % span;
      a0 = g * 2 * span + o;
      a1 = a0 + span;
      tw = o * (N/2) / span;
      e_mr[c0+1+p] = 1;
      e_a0[c0+1+p] = LOG_N'(a0);
      e_a1[c0+1+p] = LOG_N'(a1);
      e_nd[c0+3+p] = 1;
      e_d0[c0+3+p] = mem[a0];
      e_d1[c0+3+p] = mem[a1];
      e_tw[c0+3+p] = (LOG_N-1)'(tw);
      e_m[c0+3+p]  = m_const;
    end
    e_fin[c0+N/2+2] = 1;
  endtask

  task automatic do_start(input int s);
    int c0;
    c0 = cyc;
    if (c0 >= busy_until && s < LOG_N) begin
      model_run(c0, s);
      busy_until = c0 + N/2 + 3;
    end else if (err_from > c0 + 1) begin
      err_from = c0 + 1;
    end
    start = 1'b1;
    level = LOG_N'(s);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_capture();
    q_d0.delete(); q_d1.delete(); q_tw.delete();
    fin_cyc = -1;
    err_rise = -1;
    mr_count = 0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_nd", 64'(out_nd), 64'(0));
    chk("rst_out_mread", 64'(out_mread), 64'(0));
    chk("rst_finished", 64'(finished), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_addr1", 64'(addr1), 64'(0));
    chk("rst_out_data1", 64'(out_data1), 64'(0));
    clear_model_from(cyc);
    err_from = BIG;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_until = cyc;
  endtask

  task automatic pin_run(input int c0, input int s);
    int x0[4], x1[4], xt[4];
    case (s)
      0: begin x0 = '{0,2,4,6}; x1 = '{1,3,5,7}; xt = '{0,0,0,0}; end
      1: begin x0 = '{0,1,4,5}; x1 = '{2,3,6,7}; xt = '{0,2,0,2}; end
      default: begin x0 = '{0,1,2,3}; x1 = '{4,5,6,7}; xt = '{0,1,2,3}; end
    endcase
    chk("pin_pair_count", 64'(q_d0.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < q_d0.size()) begin
        chk("pin_data0", 64'(q_d0[k]), 64'(x0[k]));
        chk("pin_data1", 64'(q_d1[k]), 64'(x1[k]));
        chk("pin_tw", 64'(q_tw[k]), 64'(xt[k]));
      end
    end
    chk("pin_finished_cycle", 64'(fin_cyc - c0), 64'(6));
    chk("pin_mread_count", 64'(mr_count), 64'(4));
  endtask

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (!rst_n) begin
      chk("reset_out_nd", 64'(out_nd), 64'(0));
      chk("reset_out_mread", 64'(out_mread), 64'(0));
      chk("reset_finished", 64'(finished), 64'(0));
      chk("reset_error", 64'(error), 64'(0));
      chk("reset_addr0", 64'(addr0), 64'(0));
      chk("reset_out_data0", 64'(out_data0), 64'(0));
      chk("reset_out_tw", 64'(out_tw), 64'(0));
      chk("reset_out_m", 64'(out_m), 64'(0));
    end else if (c < DEPTH) begin
      chk("out_nd", 64'(out_nd), 64'(e_nd[c]));
      chk("out_mread", 64'(out_mread), 64'(e_mr[c]));
      chk("finished", 64'(finished), 64'(e_fin[c]));
      chk("error", 64'(error), 64'(c >= err_from));
      if (e_mr[c]) begin
        chk("addr0", 64'(addr0), 64'(e_a0[c]));
        chk("addr1", 64'(addr1), 64'(e_a1[c]));
      end
      if (e_nd[c]) begin
        chk("out_data0", 64'(out_data0), 64'(e_d0[c]));
        chk("out_data1", 64'(out_data1), 64'(e_d1[c]));
        chk("out_tw", 64'(out_tw), 64'(e_tw[c]));
        chk("out_m", 64'(out_m), 64'(e_m[c]));
      end
      if (out_nd) begin
        q_d0.push_back(out_data0);
        q_d1.push_back(out_data1);
        q_tw.push_back(out_tw);
      end
      if (finished) fin_cyc = c;
      if (out_mread) mr_count++;
      if (error && err_rise < 0) err_rise = c;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) mem[i] = WIDTH'(i);
    m_const = 1'b1;
    clear_model_from(0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_until = cyc;
    wait_to(cyc + 2);

    // single runs at each level
    for (int s = 0; s < LOG_N; s++) begin
      clear_capture();
      c0 = cyc;
      do_start(s);
      wait_to(c0 + N/2 + 4);
      pin_run(c0, s);
    end

    // start arriving mid-run is ignored but flagged
    clear_capture();
    c0 = cyc;
    do_start(1);
    wait_to(c0 + 2);
    do_start(0);
    wait_to(c0 + N/2 + 4);
    pin_run(c0, 1);
    chk("pin_error_rise_cycle", 64'(err_rise - c0), 64'(3));

    // out-of-range level
    hard_reset();
    clear_capture();
    c0 = cyc;
    do_start(LOG_N);
    wait_to(c0 + N/2 + 4);
    chk("bad_level_mread_count", 64'(mr_count), 64'(0));
    chk("bad_level_nd_count", 64'(q_d0.size()), 64'(0));
    chk("bad_level_error", 64'(error), 64'(1));

    // back-to-back runs with non-trivial data and metadata
    hard_reset();
    for (int i = 0; i < N; i++) mem[i] = 32'hC0DE0000 + WIDTH'(i * 7);
    m_const = 1'b0;
    clear_capture();
    c0 = cyc;
    do_start(2);
    wait_to(c0 + N/2 + 3);
    do_start(0);
    wait_to(c0 + 2 * (N/2 + 3) + 1);
    chk("b2b_pair_count", 64'(q_d0.size()), 64'(8));
    chk("b2b_error", 64'(error), 64'(0));

    // reset in the middle of a run, then a clean run
    for (int i = 0; i < N; i++) mem[i] = WIDTH'(i);
    m_const = 1'b1;
    c0 = cyc;
    do_start(1);
    wait_to(c0 + 3);
    hard_reset();
    clear_capture();
    c0 = cyc;
    do_start(2);
    wait_to(c0 + N/2 + 4);
    pin_run(c0, 2);
    chk("post_reset_error", 64'(error), 64'(0));

    wait_to(cyc + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
